finite_mod_accum: RTL

Parametrised modular accumulator: the sequential, width/modulus-generic successor of the fixed 7-bit "(x + 1) mod 100" device. It keeps a running value in the finite ring Z_M and adds a per-cycle step, reduced mod M, when enabled. It supports synchronous load and reports wrap-around. It sits in the ReWire regression/device set as a clocked top-level with packed `__in0`/`__out0` vectors.

---
 rtl/finite_mod_accum.sv | 97 +++++++++
 1 files changed

// File: rtl/finite_mod_accum.sv
// Two-stage modular accumulator over Z_M: stage 1 reduces the step mod M, stage 2 accumulates and flags wrap.
// Optional wrap counter on __out1 enabled by defining FINITE_MOD_ACCUM_WRAPCNT_EN.
module finite_mod_accum #(
    parameter int W  = 7,
    parameter int M  = 100,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W+1:0]  __in0,
    output logic [W:0]    __out0
`ifdef FINITE_MOD_ACCUM_WRAPCNT_EN
    ,
    output logic [CW-1:0] __out1
`endif
);

    generate
        if (M < 2 || longint'(M) > (longint'(1) << W)) begin : g_bad_modulus
            $error("finite_mod_accum: M must satisfy 2 <= M <= 2**W");
        end
        if (CW < 1) begin : g_bad_cw
            $error("finite_mod_accum: CW must be at least 1");
        end
    endgenerate

    // M may equal 2**W, so it needs one bit more than the data path.
    localparam logic [W:0] MOD_W = (W+1)'(M);

    function automatic logic [W-1:0] mod_reduce(input logic [W-1:0] d);
        return W'({1'b0, d} % MOD_W);
    endfunction

    // Returns {wrap, (a + b) mod M}; both operands are already below M.
    function automatic logic [W:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= MOD_W) begin
            return {1'b1, W'(sum - MOD_W)};
        end
        return {1'b0, sum[W-1:0]};
    endfunction

    logic         load_p1;
    logic         vld_p1;
    logic [W-1:0] r_p1;
    logic [W-1:0] acc_p2;
    logic         wrap_p2;

    // Stage 1: capture command and reduce the step into [0, M-1]
    always_ff @(posedge clk) begin
        if (rst) begin
            load_p1 <= 1'b0;
            vld_p1  <= 1'b0;
            r_p1    <= '0;
        end else begin
            load_p1 <= __in0[W+1];
            vld_p1  <= __in0[W];
            r_p1    <= mod_reduce(__in0[W-1:0]);
        end
    end

    // Stage 2: load has priority over accumulate; wrap is a single-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p2  <= '0;
            wrap_p2 <= 1'b0;
        end else if (load_p1) begin
            acc_p2  <= r_p1;
            wrap_p2 <= 1'b0;
        end else if (vld_p1) begin
            {wrap_p2, acc_p2} <= mod_add(acc_p2, r_p1);
        end else begin
            wrap_p2 <= 1'b0;
        end
    end

    assign __out0 = {wrap_p2, acc_p2};

`ifdef FINITE_MOD_ACCUM_WRAPCNT_EN
    logic [CW-1:0] wrap_cnt_p2;
    logic [W:0]    add_res;

    assign add_res = mod_add(acc_p2, r_p1);

    always_ff @(posedge clk) begin
        if (rst || load_p1) begin
            wrap_cnt_p2 <= '0;
        end else if (vld_p1 && add_res[W]) begin
            wrap_cnt_p2 <= wrap_cnt_p2 + 1'b1;
        end
    end

    assign __out1 = wrap_cnt_p2;
`endif

endmodule
